ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NM, default 3: number of bus masters; 2..4 supported.
REQ-002 Parameter DEFAULT_M, default 0: master index granted when no requests are pending.
REQ-003 Port HCLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port HBUSREQ, input, NM bits: bus request, one bit per master.
REQ-006 Port HTRANS, input, 2 bits: muxed transfer type of the current address-phase owner.
REQ-007 Port HBURST, input, 3 bits: muxed burst type of the current address-phase owner.
REQ-008 Port HREADY, input, 1 bit: bus ready; an address or data phase completes on an edge where HREADY=1.
REQ-009 Port HGRANT, output, NM bits: one-hot registered grant.
REQ-010 Port HMASTER, output, 2 bits: index of the address-phase owner; drives the address/control mux.
REQ-011 Port HMASTER_D, output, 2 bits: index of the data-phase owner; drives the write-data mux.

Function
REQ-012 HGRANT shall be exactly one-hot in every cycle after reset.
REQ-013 An "accepted" transfer is HTRANS in {NONSEQ, SEQ} at an edge with HREADY=1.
REQ-014 Burst counter cnt shall load len-1 on an accepted NONSEQ, where len is 4 for INCR4/WRAP4, 8 for INCR8/WRAP8, 16 for INCR16/WRAP16, and 1 otherwise.
REQ-015 On an accepted SEQ with cnt>0, cnt shall decrement by 1.
REQ-016 cnt shall hold on BUSY or HREADY=0.
REQ-017 cnt shall clear on IDLE at an edge with HREADY=1, which covers early burst termination.
REQ-018 Arbitration point: an edge with HREADY=1 where the next value of cnt is at most 1. HGRANT may change only at arbitration points.
REQ-019 At an arbitration point, the winner shall be the first requesting master in round-robin order, starting from (index of last winner + 1) mod NM.
REQ-020 If no master requests at an arbitration point, the grant shall go to DEFAULT_M.
REQ-021 The round-robin pointer shall update only when the winner was selected from a live request.
REQ-022 A sole requester shall keep its grant indefinitely.
REQ-023 A master that drops HBUSREQ mid fixed-length burst shall keep its grant until the next arbitration point.
REQ-024 HMASTER shall take the index of the asserted HGRANT bit on every edge with HREADY=1, and hold otherwise. Handover latency: grant at edge E; the new owner drives its address at the first HREADY=1 edge after E.
REQ-025 HMASTER_D shall take HMASTER on every edge with HREADY=1, and hold otherwise.
REQ-026 While HREADY=0, all outputs and all internal state shall hold.

Reset
REQ-027 While HRESETn=0: HGRANT = one-hot(DEFAULT_M), HMASTER = DEFAULT_M, HMASTER_D = DEFAULT_M, cnt = 0, round-robin pointer = DEFAULT_M.
REQ-028 Reset assertion mid-burst shall abandon the burst immediately; no partial state is retained.
REQ-029 After HRESETn deasserts, the first edge with HREADY=1 shall be an arbitration point.

Structure
REQ-030 Package ahb_arb_pkg shall hold the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-031 ahb_arb_pkg shall also hold the HBURST encodings (SINGLE=000 ... INCR16=111) and the burst-length decode function.
REQ-032 Round-robin selection shall live in one combinational sub-module, rr_pick: request vector plus pointer in, one-hot winner plus valid out.
REQ-033 The arbiter shall remain a separate module that the decoder, the slave mux, and existing single-transfer masters connect to unchanged.

Verification
REQ-034 Reset test: reset with HBUSREQ=000 -> HGRANT=001, HMASTER=0, HMASTER_D=0; holds with no requests.
REQ-035 Round-robin test: HBUSREQ=111 with continuous SINGLE NONSEQ and HREADY=1 -> grant sequence 001, 010, 100, 001 on successive arbitration points.
REQ-036 Burst hold test: master1 issues an INCR4 with HBUSREQ=011 -> HGRANT stays 010 until the edge accepting the 3rd beat. HMASTER switches to 0 on the edge accepting the 4th beat.
REQ-037 Wait-state test: HREADY=0 for 3 cycles mid-INCR8 -> cnt, HGRANT, HMASTER and HMASTER_D are all frozen, then resume with the correct count.
REQ-038 Early termination test: IDLE after beat 2 of WRAP8 -> cnt=0; rearbitration occurs at that edge.
REQ-039 Async reset test: HRESETn pulsed low between clock edges during a burst -> outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter definitions: transfer-type and burst-type encodings and
// the burst-length decode used to load the arbiter's beat counter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_t;

  localparam int CNT_W = 4;

  // Number of beats in a fixed-length burst. SINGLE and undefined-length
  // INCR count as one beat: the arbiter may rearbitrate after every beat.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst_t'(hburst))
      HB_WRAP4,  HB_INCR4:  len = 5'd4;
      HB_WRAP8,  HB_INCR8:  len = 5'd8;
      HB_WRAP16, HB_INCR16: len = 5'd16;
      default:              len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per master
//   ptr  : index of the last winner; search starts at (ptr + 1) mod NM
//   gnt  : one-hot winner (all zero when nothing requests)
//   vld  : a live request was found
module rr_pick #(
  parameter int NM = 3
) (
  input  logic [NM-1:0] req,
  input  logic [1:0]    ptr,
  output logic [NM-1:0] gnt,
  output logic          vld
);
  import ahb_arb_pkg::*;

  logic [1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < NM; i++) begin
      idx = 2'((int'(ptr) + 1 + i) % NM);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with burst-aware round-robin arbitration.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HBUSREQ       : per-master bus request
//   HTRANS/HBURST : transfer and burst type of the current address-phase owner
//   HREADY        : bus ready; everything freezes while it is low
//   HGRANT        : registered one-hot grant
//   HMASTER       : address-phase owner index (address/control mux select)
//   HMASTER_D     : data-phase owner index (write-data mux select)
module ahb_arbiter #(
  parameter int NM        = 3,
  parameter int DEFAULT_M = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [NM-1:0] HBUSREQ,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HBURST,
  input  logic          HREADY,
  output logic [NM-1:0] HGRANT,
  output logic [1:0]    HMASTER,
  output logic [1:0]    HMASTER_D
);
  import ahb_arb_pkg::*;

  localparam logic [1:0]    DEF_IDX = 2'(DEFAULT_M);
  localparam logic [NM-1:0] DEF_GNT = NM'(1) << DEFAULT_M;

  function automatic logic [1:0] oh_idx(input logic [NM-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NM; i++)
      if (oh[i]) r = 2'(i);
    return r;
  endfunction

  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       ptr_p1;
  logic             first_p1;
  logic             arb;
  logic [NM-1:0]    pick_gnt;
  logic             pick_vld;

  // Beats remaining in the current burst. A NONSEQ with HREADY=0 is not
  // accepted, so the whole update sits under HREADY.
  always_comb begin
    cnt_nxt = cnt_p1;
    if (HREADY) begin
      case (htrans_t'(HTRANS))
        HT_NONSEQ: cnt_nxt = CNT_W'(burst_len(HBURST) - 5'd1);
        HT_SEQ:    cnt_nxt = (cnt_p1 != '0) ? cnt_p1 - 1'b1 : cnt_p1;
        HT_IDLE:   cnt_nxt = '0;
        default:   cnt_nxt = cnt_p1;
      endcase
    end
  end

  // Rearbitrate when at most one beat remains, so the next owner is granted
  // while the final beat's address phase is still in flight. The first ready
  // edge after reset always rearbitrates, whatever the bus shows.
  assign arb = HREADY && (first_p1 || (cnt_nxt <= CNT_W'(1)));

  rr_pick #(.NM(NM)) u_pick (
    .req (HBUSREQ),
    .ptr (ptr_p1),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  // ---- register stage: grant, owner pipeline, burst counter ----
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT    <= DEF_GNT;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      cnt_p1    <= '0;
      ptr_p1    <= DEF_IDX;
      first_p1  <= 1'b1;
    end else if (HREADY) begin
      cnt_p1    <= cnt_nxt;
      first_p1  <= 1'b0;
      HMASTER   <= oh_idx(HGRANT);
      HMASTER_D <= HMASTER;
      if (arb) begin
        if (pick_vld) begin
          HGRANT <= pick_gnt;
          ptr_p1 <= oh_idx(pick_gnt);
        end else begin
          // Parking on the default master leaves the pointer alone.
          HGRANT <= DEF_GNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
  localparam int NM = 3;

  localparam logic [1:0] IDL = 2'b00, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, WR8 = 3'b100, IN4 = 3'b011, IN8 = 3'b101, IN16 = 3'b111;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [NM-1:0] HBUSREQ;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [NM-1:0] HGRANT;
  logic [1:0]    HMASTER;
  logic [1:0]    HMASTER_D;

  ahb_arbiter #(.NM(NM), .DEFAULT_M(0)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [NM-1:0] gnt;
    logic [1:0]    hm;
    logic [1:0]    hmd;
    logic [3:0]    cnt;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  task automatic push(input logic [NM-1:0] g, input logic [1:0] m, input logic [1:0] md,
                      input logic [3:0] c, input string nm);
    exp_t e;
    e.gnt = g; e.hm = m; e.hmd = md; e.cnt = c; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic [NM-1:0] req, input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic [NM-1:0] g, input logic [1:0] m,
                      input logic [1:0] md, input logic [3:0] c, input string nm);
    @(negedge HCLK);
    HBUSREQ = req; HTRANS = tr; HBURST = bu; HREADY = rdy;
    push(g, m, md, c, nm);
  endtask

  // Monitor: compares after every rising edge, or immediately on request
  // for checks that must not wait for a clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK or chk_now);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (HGRANT !== e.gnt || HMASTER !== e.hm || HMASTER_D !== e.hmd ||
            dut.cnt_p1 !== e.cnt || !$onehot(HGRANT)) begin
          n_bad++;
          $display("FAIL %s: got gnt=%b hm=%0d hmd=%0d cnt=%0d, expected gnt=%b hm=%0d hmd=%0d cnt=%0d",
                   e.name, HGRANT, HMASTER, HMASTER_D, dut.cnt_p1, e.gnt, e.hm, e.hmd, e.cnt);
        end
      end
    end
  end

  initial begin
    HRESETn = 1'b0; HBUSREQ = '0; HTRANS = IDL; HBURST = SGL; HREADY = 1'b1;

    // Reset and idle parking
    step(3'b000, IDL, SGL, 1, 3'b001, 0, 0, 0,  "reset");
    @(posedge HCLK); #2 HRESETn = 1'b1;
    step(3'b000, IDL, SGL, 1, 3'b001, 0, 0, 0,  "idle_a");
    step(3'b000, IDL, SGL, 1, 3'b001, 0, 0, 0,  "idle_b");

    // Round robin with all masters requesting single transfers
    step(3'b111, NSQ, SGL, 1, 3'b010, 0, 0, 0,  "rr_1");
    step(3'b111, NSQ, SGL, 1, 3'b100, 1, 0, 0,  "rr_2");
    step(3'b111, NSQ, SGL, 1, 3'b001, 2, 1, 0,  "rr_3");
    step(3'b111, NSQ, SGL, 1, 3'b010, 0, 2, 0,  "rr_4");

    // INCR4 from master 1 with master 0 waiting
    step(3'b010, IDL, SGL, 1, 3'b010, 1, 0, 0,  "m1_own");
    step(3'b011, NSQ, IN4, 1, 3'b010, 1, 1, 3,  "inc4_b1");
    step(3'b011, SQ,  IN4, 1, 3'b010, 1, 1, 2,  "inc4_b2");
    step(3'b011, SQ,  IN4, 1, 3'b001, 1, 1, 1,  "inc4_b3");
    step(3'b001, SQ,  IN4, 1, 3'b001, 0, 1, 0,  "inc4_b4");

    // INCR8 with three wait states; noise on HTRANS/HBURST while stalled
    step(3'b001, NSQ, IN8, 1, 3'b001, 0, 0, 7,  "inc8_b1");
    step(3'b110, SQ,  IN8, 1, 3'b001, 0, 0, 6,  "inc8_b2");
    step(3'b110, NSQ, IN16, 0, 3'b001, 0, 0, 6, "wait_1");
    step(3'b110, NSQ, IN16, 0, 3'b001, 0, 0, 6, "wait_2");
    step(3'b110, NSQ, IN16, 0, 3'b001, 0, 0, 6, "wait_3");
    step(3'b110, SQ,  IN8, 1, 3'b001, 0, 0, 5,  "inc8_b3");
    step(3'b110, SQ,  IN8, 1, 3'b001, 0, 0, 4,  "inc8_b4");
    step(3'b110, SQ,  IN8, 1, 3'b001, 0, 0, 3,  "inc8_b5");
    step(3'b110, SQ,  IN8, 1, 3'b001, 0, 0, 2,  "inc8_b6");
    step(3'b110, SQ,  IN8, 1, 3'b010, 0, 0, 1,  "inc8_b7");
    step(3'b110, SQ,  IN8, 1, 3'b100, 1, 0, 0,  "inc8_b8");

    // WRAP8 terminated early by IDLE after beat 2
    step(3'b100, IDL, SGL, 1, 3'b100, 2, 1, 0,  "m2_own");
    step(3'b101, NSQ, WR8, 1, 3'b100, 2, 2, 7,  "wr8_b1");
    step(3'b101, SQ,  WR8, 1, 3'b100, 2, 2, 6,  "wr8_b2");
    step(3'b101, IDL, WR8, 1, 3'b001, 2, 2, 0,  "wr8_idle");
    step(3'b101, IDL, SGL, 1, 3'b100, 0, 2, 0,  "after_idle");

    // Asynchronous reset mid-INCR16, then forced arbitration on first edge
    step(3'b100, NSQ, IN16, 1, 3'b100, 2, 0, 15, "i16_b1");
    step(3'b100, SQ,  IN16, 1, 3'b100, 2, 2, 14, "i16_b2");
    @(negedge HCLK);
    #1;
    HRESETn = 1'b0;
    push(3'b001, 0, 0, 0, "async_rst");
    ->chk_now;
    #2 HRESETn = 1'b1;
    HBUSREQ = 3'b100; HTRANS = NSQ; HBURST = IN16; HREADY = 1'b1;
    push(3'b100, 0, 0, 15, "post_rst_arb");
    step(3'b100, SQ,  IN16, 1, 3'b100, 2, 0, 14, "post_rst_b2");

    // No requests parks on default without moving the pointer
    step(3'b000, IDL, SGL, 1, 3'b001, 2, 2, 0,  "park");
    step(3'b011, IDL, SGL, 1, 3'b001, 0, 2, 0,  "ptr_kept");

    @(posedge HCLK);
    #3;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
